elastic_pipeline_register: RTL



---
 rtl/elastic_pipeline_register.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/elastic_pipeline_register.sv
// Purpose : STAGES-deep valid/ready register chain with bubble collapse and an optional
//           one-entry input skid buffer (SKID=1) that makes in_ready a pure register output.
// Latency : STAGES cycles from input acceptance to out_valid; the skid adds none when unused.
// Backpr. : stage i advances when it is empty or stage i+1 advances; capacity STAGES+SKID beats.
//
// Ports:
//   clk, rst_n             single clock, synchronous active-low reset
//   in_valid/in_ready/in_data     upstream stream
//   out_valid/out_ready/out_data  downstream stream (out_data = last stage payload)
//   occupancy              registered count of beats held (stages + skid)
//   flush                  only when ELASTIC_PIPE_FLUSH_EN is defined: synchronous discard of all
//                          held beats; blocks both transfers while high
module elastic_pipeline_register #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int SKID       = 1,
    parameter int OCC_W      = $clog2(STAGES + SKID + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ELASTIC_PIPE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    logic                  flush_w;

    logic [STAGES-1:0]     valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic [STAGES-1:0]     stage_rdy;
    logic                  in_rdy_raw;
    logic                  in_fire, out_fire;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;

`ifdef ELASTIC_PIPE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A stage can load if it or any stage after it is empty, or the sink is taking a beat.
    // Computed with a running accumulator so the chain is a plain OR tree per stage.
    always_comb begin : ready_chain
        logic acc;
        acc       = out_ready;
        stage_rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc          = acc || !valid_q[i];
            stage_rdy[i] = acc;
        end
    end

    always_comb begin
        in_rdy_raw = (SKID != 0) ? !skid_valid_q : stage_rdy[0];
        in_ready   = in_rdy_raw && rst_n && !flush_w;
        out_valid  = valid_q[STAGES-1] && rst_n && !flush_w;
        out_data   = data_q[STAGES-1];
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        occupancy  = occ_q;
    end

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        // A parked skid beat is older than anything on the input, so it feeds stage 0 first;
        // in_ready is low whenever the skid is full, so no input beat competes with it.
        if (skid_valid_q) begin
            src_valid = 1'b1;
            src_data  = skid_data_q;
        end else begin
            src_valid = in_fire;
            src_data  = in_data;
        end

        for (int i = STAGES - 1; i >= 1; i--) begin
            if (stage_rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end

        if (stage_rdy[0]) begin
            valid_d[0] = src_valid;
            if (src_valid) begin
                data_d[0] = src_data;
            end
        end

        if (SKID != 0) begin
            if (skid_valid_q) begin
                if (stage_rdy[0]) begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire && !stage_rdy[0]) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end

        occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

        // Flush drops the beats but leaves payload registers as they are.
        if (flush_w) begin
            valid_d      = '0;
            skid_valid_d = 1'b0;
            occ_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            occ_q        <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            occ_q        <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
